// File: rtl/trace_capture_if.sv
// trace_capture_if: commit-side inputs and drain-side outputs of the trace recorder
interface trace_capture_if #(
  parameter int XLEN = 32,
  parameter int SEQW = 16
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_instr;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            out_valid;
  logic            out_ready;
  logic [SEQW-1:0] out_seq;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_we;
  logic [4:0]      out_waddr;
  logic [XLEN-1:0] out_wdata;
  modport master (
    output commit_valid, commit_pc, commit_instr, rf_we, rf_waddr, rf_wdata, out_ready,
    input  out_valid, out_seq, out_pc, out_instr, out_we, out_waddr, out_wdata
  );
  modport slave (
    input  commit_valid, commit_pc, commit_instr, rf_we, rf_waddr, rf_wdata, out_ready,
    output out_valid, out_seq, out_pc, out_instr, out_we, out_waddr, out_wdata
  );
endinterface

// File: rtl/trace_capture.sv
// trace_capture: commit-trace recorder with sequence stamps, halt detection and a drain FIFO
module trace_capture #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int MODE        = 0,
  parameter int HALT_REPEAT = 4,
  parameter int SEQW        = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int RW = $clog2(HALT_REPEAT + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               arm,
  input  logic               clear,
  input  logic               stop_en,
  input  logic [XLEN-1:0]    stop_pc,
  trace_capture_if.slave     tr,
  output logic [AW:0]        count,
  output logic [15:0]        drop_cnt,
  output logic               capturing,
  output logic               halted,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, CAPTURE, HALTED, DONE} state_t;
  typedef struct packed {
    logic [SEQW-1:0] seq;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
  } entry_t;
  entry_t          mem [DEPTH];
  entry_t          head;
  state_t          state_q, state_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     count_q, count_d;
  logic [15:0]     drop_q, drop_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic [RW-1:0]   rep_q, rep_d, rep_n;
  logic [XLEN-1:0] prev_q, prev_d;
  logic            cap, rec, pop, push, halt;
  // next-state for control FSM, FIFO pointers, sequence, repeat and drop counters
  always_comb begin
    cap = tr.commit_valid && state_q == CAPTURE;
    rec = cap && (MODE == 0 || (tr.rf_we && tr.rf_waddr != 5'd0));
    pop = tr.out_valid && tr.out_ready;
    push = rec && (count_q != (AW+1)'(DEPTH) || pop);
    rep_n = (rep_q != '0 && tr.commit_pc == prev_q) ? rep_q + 1'b1 : RW'(1);
    halt = (stop_en && tr.commit_pc == stop_pc) || rep_n >= RW'(HALT_REPEAT);
    state_d = clear ? IDLE
            : ((state_q == IDLE || state_q == DONE) && arm) ? CAPTURE
            : (cap && halt) ? HALTED
            : (state_q == HALTED && count_q == '0) ? DONE
            : state_q;
    rep_d = (clear || (state_q != CAPTURE && state_d == CAPTURE)) ? '0 : cap ? rep_n : rep_q;
    prev_d = cap ? tr.commit_pc : prev_q;
    seq_d = clear ? '0 : cap ? seq_q + 1'b1 : seq_q;
    drop_d = clear ? '0 : (rec && !push && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    wr_d = clear ? '0 : push ? wr_q + 1'b1 : wr_q;
    rd_d = clear ? '0 : pop ? rd_q + 1'b1 : rd_q;
    count_d = clear ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // state and counter registers
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      drop_q  <= '0;
      seq_q   <= '0;
      rep_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      seq_q   <= seq_d;
      rep_q   <= rep_d;
      prev_q  <= prev_d;
    end
  end
  // FIFO storage; stale contents are masked at the head by out_valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= '{seq_q, tr.commit_pc, tr.commit_instr, tr.rf_we, tr.rf_waddr, tr.rf_wdata};
  end
  assign head         = tr.out_valid ? mem[rd_q] : '0;
  assign tr.out_valid = count_q != '0;
  assign tr.out_seq   = head.seq;
  assign tr.out_pc    = head.pc;
  assign tr.out_instr = head.instr;
  assign tr.out_we    = head.we;
  assign tr.out_waddr = head.waddr;
  assign tr.out_wdata = head.wdata;
  assign count        = count_q;
  assign drop_cnt     = drop_q;
  assign capturing    = state_q == CAPTURE;
  assign halted       = state_q == HALTED || state_q == DONE;
  assign done         = state_q == DONE;
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: random and directed checks of trace_capture (MODE 0 and 1) against a queue model
module tb_trace_capture;
  localparam int DEPTH = 16, HR = 4;
  localparam int S_IDLE = 0, S_CAP = 1, S_HALT = 2, S_DONE = 3;
  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;
  logic clk = 0, rstn = 1, arm = 0, clear = 0, stop_en = 0, cv = 0, ready = 0, we = 0;
  logic [31:0] stop_pc = 0, pc = 0, instr = 0, wd = 0, lastpc = 0;
  logic [4:0] wa = 0;
  logic [4:0] cnt0, cnt1;
  logic [15:0] drp0, drp1;
  logic cap0, cap1, hlt0, hlt1, dn0, dn1;
  int errors = 0, checks = 0;
  ent_t mq [2][$];
  int st [2], run [2], drops [2];
  logic [15:0] seqn [2];
  logic [31:0] prev [2];
  trace_capture_if #(.XLEN(32), .SEQW(16)) if0 ();
  trace_capture_if #(.XLEN(32), .SEQW(16)) if1 ();
  assign if0.commit_valid = cv;    assign if1.commit_valid = cv;
  assign if0.commit_pc    = pc;    assign if1.commit_pc    = pc;
  assign if0.commit_instr = instr; assign if1.commit_instr = instr;
  assign if0.rf_we        = we;    assign if1.rf_we        = we;
  assign if0.rf_waddr     = wa;    assign if1.rf_waddr     = wa;
  assign if0.rf_wdata     = wd;    assign if1.rf_wdata     = wd;
  assign if0.out_ready    = ready; assign if1.out_ready    = ready;
  trace_capture #(.DEPTH(DEPTH), .MODE(0), .HALT_REPEAT(HR)) u0 (
    .clk(clk), .rstn(rstn), .arm(arm), .clear(clear), .stop_en(stop_en), .stop_pc(stop_pc),
    .tr(if0), .count(cnt0), .drop_cnt(drp0), .capturing(cap0), .halted(hlt0), .done(dn0));
  trace_capture #(.DEPTH(DEPTH), .MODE(1), .HALT_REPEAT(HR)) u1 (
    .clk(clk), .rstn(rstn), .arm(arm), .clear(clear), .stop_en(stop_en), .stop_pc(stop_pc),
    .tr(if1), .count(cnt1), .drop_cnt(drp1), .capturing(cap1), .halted(hlt1), .done(dn1));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int ns;
      bit pop, cp, rec, halt;
      ent_t e;
      ns = st[m];
      pop = mq[m].size() != 0 && ready;
      cp = st[m] == S_CAP && cv;
      rec = cp && (m == 0 || (we && wa != 0));
      halt = 0;
      e = '0;
      if (rstn || clear) begin
        mq[m].delete();
        st[m] = S_IDLE;
        seqn[m] = 0;
        drops[m] = 0;
        run[m] = 0;
      end else begin
        if (cp) begin
          run[m] = (run[m] != 0 && pc == prev[m]) ? run[m] + 1 : 1;
          prev[m] = pc;
          halt = (stop_en && pc == stop_pc) || run[m] >= HR;
          e = '{seqn[m], pc, instr, we, wa, wd};
          seqn[m] = seqn[m] + 16'd1;
        end
        if ((st[m] == S_IDLE || st[m] == S_DONE) && arm) begin
          ns = S_CAP;
          run[m] = 0;
        end else if (st[m] == S_CAP && halt) ns = S_HALT;
        else if (st[m] == S_HALT && mq[m].size() == 0) ns = S_DONE;
        if (pop) void'(mq[m].pop_front());
        if (rec) begin
          if (mq[m].size() < DEPTH) mq[m].push_back(e);
          else if (drops[m] < 65535) drops[m]++;
        end
        st[m] = ns;
      end
    end
  endtask
  task automatic chk_dut(int m, logic [118:0] head, logic [4:0] c, logic [15:0] d, logic ca, logic h, logic dn);
    chk($sformatf("m%0d head", m), head, mq[m].size() != 0 ? {1'b1, mq[m][0]} : 119'd0);
    chk($sformatf("m%0d count", m), c, mq[m].size());
    chk($sformatf("m%0d drop_cnt", m), d, drops[m]);
    chk($sformatf("m%0d flags", m), {ca, h, dn}, {st[m] == S_CAP, st[m] >= S_HALT, st[m] == S_DONE});
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk_dut(0, {if0.out_valid, if0.out_seq, if0.out_pc, if0.out_instr, if0.out_we, if0.out_waddr, if0.out_wdata},
            cnt0, drp0, cap0, hlt0, dn0);
    chk_dut(1, {if1.out_valid, if1.out_seq, if1.out_pc, if1.out_instr, if1.out_we, if1.out_waddr, if1.out_wdata},
            cnt1, drp1, cap1, hlt1, dn1);
  endtask
  task automatic pulse_arm();
    arm = 1; step(); arm = 0;
  endtask
  task automatic pulse_clear();
    clear = 1; step(); clear = 0;
  endtask
  task automatic commit(logic [31:0] p, logic w, logic [4:0] a, logic [31:0] d);
    cv = 1; pc = p; instr = $urandom; we = w; wa = a; wd = d;
    step();
    cv = 0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 40 && !dn0; i++) step();
    chk("done reached", dn0, 1'b1);
  endtask
  initial begin
    step(); step();
    rstn = 0;
    chk("reset count", cnt0, 0);
    chk("reset out_valid", if0.out_valid, 0);
    chk("reset out_pc", if0.out_pc, 0);
    chk("reset flags", {cap0, hlt0, dn0, drp0}, 0);
    step();
    // basic capture
    pulse_arm();
    ready = 1;
    for (int i = 0; i < 3; i++) begin
      commit(32'(4 * i), 1, 1, $urandom);
      chk("basic out_valid", if0.out_valid, 1);
      chk("basic seq", if0.out_seq, i);
      chk("basic pc", if0.out_pc, 4 * i);
    end
    step();
    chk("basic drained", cnt0, 0);
    // MODE 1 filtering
    pulse_clear(); pulse_arm();
    ready = 0;
    commit(32'h40, 0, 3, 32'h1);
    commit(32'h44, 1, 5, 32'h1234);
    commit(32'h48, 0, 7, 32'h2);
    commit(32'h4c, 1, 0, 32'h3);
    chk("filter m1 count", cnt1, 1);
    chk("filter m1 seq", if1.out_seq, 1);
    chk("filter m1 waddr", if1.out_waddr, 5);
    chk("filter m1 wdata", if1.out_wdata, 32'h1234);
    chk("filter m0 count", cnt0, 4);
    // overflow
    pulse_clear(); pulse_arm();
    for (int i = 0; i < 20; i++) commit(32'h100 + 32'(4 * i), 1, 1, $urandom);
    chk("overflow count", cnt0, 16);
    chk("overflow drop", drp0, 4);
    ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("overflow order", if0.out_seq, i);
      step();
    end
    ready = 0;
    for (int i = 0; i < 16; i++) commit(32'h200 + 32'(4 * i), 1, 1, $urandom);
    chk("refill count", cnt0, 16);
    ready = 1;
    commit(32'h300, 1, 1, 32'h5);
    ready = 0;
    chk("full push+pop count", cnt0, 16);
    chk("full push+pop drop", drp0, 4);
    // self-loop halt
    pulse_clear(); pulse_arm();
    commit(32'h10, 1, 1, 1);
    for (int i = 0; i < 3; i++) commit(32'h14, 1, 1, 2);
    chk("loop not halted", hlt0, 0);
    commit(32'h14, 1, 1, 3);
    chk("loop halted", hlt0, 1);
    commit(32'h14, 1, 1, 4);
    chk("loop entries", cnt0, 5);
    ready = 1;
    wait_done();
    // stop PC then clear alongside a commit
    pulse_clear(); pulse_arm();
    ready = 0; stop_en = 1; stop_pc = 32'h20;
    commit(32'h18, 1, 1, 1);
    commit(32'h20, 1, 1, 2);
    chk("stop halted", hlt0, 1);
    chk("stop entries", cnt0, 2);
    ready = 1;
    wait_done();
    stop_en = 0;
    pulse_arm();
    clear = 1;
    commit(32'h30, 1, 1, 3);
    clear = 0;
    chk("clear idle", {cap0, hlt0, dn0}, 0);
    chk("clear count", cnt0, 0);
    ready = 0;
    pulse_arm();
    commit(32'h40, 1, 1, 4);
    chk("seq restart", if0.out_seq, 0);
    // randomized traffic
    pulse_clear(); pulse_arm();
    for (int i = 0; i < 500; i++) begin
      cv = $urandom_range(0, 3) != 0;
      pc = $urandom_range(0, 1) ? lastpc : 32'($urandom_range(0, 7) * 4);
      lastpc = pc;
      instr = $urandom; wd = $urandom;
      we = $urandom_range(0, 1); wa = 5'($urandom_range(0, 3));
      stop_en = $urandom_range(0, 7) == 0; stop_pc = 32'h1c;
      ready = $urandom_range(0, 2) != 0;
      arm = $urandom_range(0, 15) == 0;
      clear = $urandom_range(0, 99) == 0;
      step();
    end
    cv = 0; arm = 0; clear = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Synthesizable commit-trace recorder attached to the CPU commit/writeback interface in sccomp.
- Records PC, instruction and register-file write per committed instruction into a parametrised FIFO, stamped with a commit sequence number.
- Detects program end: a stop PC, or a self-loop held for HALT_REPEAT commits.
- A valid/ready drain port feeds a UART or debug reader.

Parameters:
- XLEN, 32, data/PC width
- DEPTH, 16, FIFO entries; power of two, minimum 2
- MODE, 0, 0 = record every commit; 1 = record only commits with rf_we=1 and rf_waddr!=0
- HALT_REPEAT, 4, consecutive commits of the same PC that declare halt; minimum 2
- SEQW, 16, sequence-stamp width

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous reset, active-high (rstn=1 resets on the clock edge; name follows the codebase)
- arm  in  1  one-cycle pulse; IDLE -> CAPTURE
- clear  in  1  one-cycle pulse; flush FIFO and counters, go to IDLE
- stop_en  in  1  enable stop-PC compare
- stop_pc  in  XLEN  stop address
- commit_valid  in  1  one instruction retires this cycle
- commit_pc  in  XLEN  PC of the retiring instruction
- commit_instr  in  32  instruction word
- rf_we  in  1  register write enable of the retiring instruction
- rf_waddr  in  5  destination register
- rf_wdata  in  XLEN  write data
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head
- out_seq  out  SEQW  commit sequence number of the head
- out_pc  out  XLEN  head PC
- out_instr  out  32  head instruction
- out_we  out  1  head register write enable
- out_waddr  out  5  head destination register
- out_wdata  out  XLEN  head write data
- count  out  log2(DEPTH)+1  FIFO occupancy
- drop_cnt  out  16  entries lost to overflow, saturating
- capturing  out  1  state==CAPTURE
- halted  out  1  state is HALTED or DONE
- done  out  1  state==DONE

Behaviour:
- Reset: state IDLE, FIFO empty, count=0, drop_cnt=0, seq=0, repeat counter=0. All out_* fields read 0; out_valid=0, capturing=0, halted=0, done=0.
- States:
  - IDLE: ignore commits; on arm -> CAPTURE.
  - CAPTURE: record commits; on halt condition -> HALTED.
  - HALTED: no capture; drain continues; when count==0 -> DONE.
  - DONE: idle; arm -> CAPTURE (seq not reset).
- clear: from any state, same cycle priority over everything except rstn. Next cycle: IDLE, FIFO empty, seq=0, drop_cnt=0.
- Sequence counter:
  - Increments on every commit_valid in CAPTURE, including commits MODE 1 filters out; wraps at 2^SEQW.
  - A recorded entry carries the seq value before the increment.
  - The first commit after reset or clear gets seq 0.
- Halt condition, evaluated on commit_valid in CAPTURE:
  - (stop_en && commit_pc==stop_pc), or
  - commit_pc equal to the previous commit's PC for HALT_REPEAT consecutive commits. The repeat counter resets to 1 on a PC change.
  - The halting commit is itself recorded, subject to MODE; the state is HALTED from the next cycle.
- Push latency: an entry committed in cycle N appears at the FIFO head, with out_valid, in cycle N+1 if the FIFO was empty.
- Pop: a handshake occurs when out_valid && out_ready. Out fields stay stable while out_valid=1 and out_ready=0.
- Full: a push when count==DEPTH with no simultaneous pop drops the entry; drop_cnt +1, saturating at 16'hFFFF.
- Simultaneous push and pop when full: both occur, no drop, count unchanged.
- Simultaneous push and pop when empty: the push is stored; the pop is a no-op because out_valid=0.
- Pointers wrap modulo DEPTH; count is never above DEPTH.

Test Plan:
- Basic capture, MODE=0: arm, then 3 commits at PC 0x0,0x4,0x8 with out_ready=1 -> 3 entries with seq 0,1,2 and matching PC/instr; each entry's out_valid rises one cycle after its commit.
- Filter, MODE=1: 4 commits where only the 2nd (waddr=5, wdata=0x1234) and 4th (waddr=0) have rf_we=1 -> exactly 1 entry, seq=1, waddr=5, wdata=0x1234.
- Overflow, DEPTH=16: out_ready=0, 20 commits -> count=16, drop_cnt=4. Then release out_ready -> heads seq 0..15 in order.
- Full with simultaneous push/pop: count=16, one cycle with commit_valid=1 and out_ready=1 -> count stays 16, drop_cnt unchanged.
- Self-loop halt, HALT_REPEAT=4: commits PC 0x10,0x14,0x14,0x14,0x14,0x14 -> halted the cycle after the 4th 0x14. 5 entries recorded; the 6th commit is ignored. After draining, done=1.
- Stop PC and clear: stop_en=1, stop_pc=0x20, commit at 0x20 -> halted. A clear in the same cycle as a later commit -> next cycle IDLE, count=0, seq restarts at 0 on the next arm.
